aead_serial_loader: RTL and testbench
=====================================

AEAD_SERIAL_LOADER -- requirements
Module: aead_serial_loader

Interface
REQ-001 Parameter K, default 128, key length in bits.
REQ-002 Parameter Y, default 64, plaintext length in bits.
REQ-003 Parameter L, default 40, associated-data length in bits.
REQ-004 Parameter START_CYCLES, default 5, encryption-start pulse length in clocks, range 1..15.
REQ-005 Derived constant MAX_LEN SHALL be max(K, Y, L, 128); the 128 term covers the fixed 128-bit nonce.
REQ-006 Port clk, input, 1: the single clock; every register is updated on its rising edge.
REQ-007 Port rst, input, 1: reset, synchronous and active-high.
REQ-008 Port load_validxSI, input, 1: the parallel operands are valid.
REQ-009 Port load_readyxSO, output, 1: the block accepts a load.
REQ-010 Port keyxDI, input, K: key, MSB first on the wire.
REQ-011 Port noncexDI, input, 128: nonce.
REQ-012 Port associated_dataxDI, input, L: associated data.
REQ-013 Port plain_textxDI, input, Y: plaintext.
REQ-014 Ports keyxSO, noncexSO, associated_dataxSO, plain_textxSO, output, 1 each: serial bits driven to the AEAD core.
REQ-015 Port shift_enxSO, output, 1: the serial bits are valid in this cycle.
REQ-016 Port encryption_startxSO, output, 1: start request to the AEAD core.
REQ-017 Port encryption_readyxSI, input, 1: done indication from the AEAD core.
REQ-018 Port donexSO, output, 1: one-cycle completion pulse.

Function
REQ-019 The FSM SHALL have five states (IDLE, SHIFT, START, WAIT, DONE), reset to IDLE.
REQ-020 load_readyxSO SHALL be 1 only in IDLE.
REQ-021 IDLE: on load_validxSI=1, capture all four operands, clear bit counter i to 0, and enter SHIFT next cycle.
REQ-022 load_validxSI outside IDLE SHALL be ignored and SHALL NOT alter the captured operands.
REQ-023 SHIFT: shift_enxSO=1 for exactly MAX_LEN consecutive cycles, with i=0..MAX_LEN-1.
REQ-024 In SHIFT cycle i, keyxSO SHALL equal key[K-1-i] if i<K, else 0.
REQ-025 In SHIFT cycle i, noncexSO SHALL equal nonce[127-i].
REQ-026 In SHIFT cycle i, plain_textxSO SHALL equal pt[Y-1-i] if i<Y, else 0.
REQ-027 In SHIFT cycle i, associated_dataxSO SHALL equal ad[L-1-i] if i<L, else 0.
REQ-028 After the cycle with i=MAX_LEN-1, the FSM SHALL enter START; the counter SHALL be clog2(MAX_LEN+1) bits and SHALL NOT wrap during SHIFT.
REQ-029 START: encryption_startxSO=1 for exactly START_CYCLES cycles, then enter WAIT.
REQ-030 WAIT: encryption_startxSO=0; the FSM SHALL remain until it samples encryption_readyxSI=1, then enter DONE.
REQ-031 encryption_readyxSI SHALL be ignored outside WAIT; if it is already high on entry to WAIT, the FSM SHALL advance on the first WAIT cycle.
REQ-032 DONE: donexSO=1 for one cycle, then return to IDLE, with load_readyxSO=1 on the following cycle.
REQ-033 Outside SHIFT, all serial data outputs and shift_enxSO SHALL be 0.
REQ-034 All outputs SHALL be registered; there is no combinational path from any input to any output.
REQ-035 Total latency from load acceptance to donexSO SHALL be 1+MAX_LEN+START_CYCLES+W+1 cycles, where W is the number of WAIT cycles (at least 1).

Reset
REQ-036 When rst=1 at a clock edge, the block SHALL go to IDLE, clear the counter, clear the operand registers to 0, and drive all outputs to 0 except load_readyxSO.
REQ-037 load_readyxSO SHALL be 1 in the cycle after rst is released.
REQ-038 rst in any state, including mid-SHIFT or mid-START, SHALL abort the transaction immediately, with no further shift_en or start cycles.
REQ-039 rst has priority over load_validxSI in the same cycle.

Verification
REQ-040 Nominal: K=128, Y=64, L=40, key=0x000102..0F, nonce=0x101112..1F, ad=0xA5A5A5A5A5, pt=0x0123456789ABCDEF; load, then capture 128 serial bits -> rebuilt words match the inputs, bits beyond Y/L are 0, shift_en is high for exactly 128 cycles, and start is high for exactly 5 cycles.
REQ-041 Ready handshake: hold encryption_readyxSI low for 20 WAIT cycles, then raise it -> donexSO pulses exactly once, 2 cycles after ready is raised; load_readyxSO returns the next cycle.
REQ-042 Early ready: encryption_readyxSI held at 1 throughout -> START still lasts 5 cycles; WAIT lasts 1 cycle; total latency is 1+128+5+1+1 = 136 cycles.
REQ-043 Reset mid-SHIFT at i=50 -> next cycle all outputs are 0 and load_ready=1; a fresh load then shifts from bit 0 of the new operands.
REQ-044 Load during busy: pulse load_validxSI with different operands while in SHIFT and in WAIT -> no effect, and the serial stream matches the first operands.
REQ-045 Back-to-back: two loads with load_valid held high -> the second is accepted on the first IDLE cycle after DONE, with no bit lost or duplicated.

Source files
------------

// File: rtl/aead_serial_loader.sv
// Accepts parallel key/nonce/AD/plaintext operands, streams them MSB-first to a
// bit-serial AEAD core, then issues the start request and waits for completion.
module aead_serial_loader #(
  parameter int K            = 128,
  parameter int Y            = 64,
  parameter int L            = 40,
  parameter int START_CYCLES = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_validxSI,
  output logic         load_readyxSO,
  input  logic [K-1:0] keyxDI,
  input  logic [127:0] noncexDI,
  input  logic [L-1:0] associated_dataxDI,
  input  logic [Y-1:0] plain_textxDI,
  output logic         keyxSO,
  output logic         noncexSO,
  output logic         associated_dataxSO,
  output logic         plain_textxSO,
  output logic         shift_enxSO,
  output logic         encryption_startxSO,
  input  logic         encryption_readyxSI,
  output logic         donexSO
);

  localparam int KY      = (K > Y) ? K : Y;
  localparam int KYL     = (KY > L) ? KY : L;
  localparam int MAX_LEN = (KYL > 128) ? KYL : 128;
  localparam int CW      = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, START, WAIT, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  i;
  logic [3:0]     start_cnt;
  logic [K-1:0]   key_sr;
  logic [127:0]   nonce_sr;
  logic [L-1:0]   ad_sr;
  logic [Y-1:0]   pt_sr;
  logic           accept;

  // load_readyxSO is high only while the FSM idles, so it doubles as the accept gate
  assign accept = load_readyxSO && load_validxSI;

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      i                   <= '0;
      start_cnt           <= '0;
      key_sr              <= '0;
      nonce_sr            <= '0;
      ad_sr               <= '0;
      pt_sr               <= '0;
      load_readyxSO       <= 1'b1;
      keyxSO              <= 1'b0;
      noncexSO            <= 1'b0;
      associated_dataxSO  <= 1'b0;
      plain_textxSO       <= 1'b0;
      shift_enxSO         <= 1'b0;
      encryption_startxSO <= 1'b0;
      donexSO             <= 1'b0;
    end else begin
      load_readyxSO       <= 1'b0;
      keyxSO              <= 1'b0;
      noncexSO            <= 1'b0;
      associated_dataxSO  <= 1'b0;
      plain_textxSO       <= 1'b0;
      shift_enxSO         <= 1'b0;
      encryption_startxSO <= 1'b0;
      donexSO             <= 1'b0;
      case (state)
        IDLE: begin
          load_readyxSO <= !accept;
          if (accept) begin
            key_sr   <= keyxDI;
            nonce_sr <= noncexDI;
            ad_sr    <= associated_dataxDI;
            pt_sr    <= plain_textxDI;
            i        <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // Zero fill makes shorter operands read as 0 once their bits run out
          shift_enxSO        <= 1'b1;
          keyxSO             <= key_sr[K-1];
          noncexSO           <= nonce_sr[127];
          associated_dataxSO <= ad_sr[L-1];
          plain_textxSO      <= pt_sr[Y-1];
          key_sr             <= {key_sr[K-2:0], 1'b0};
          nonce_sr           <= {nonce_sr[126:0], 1'b0};
          ad_sr              <= {ad_sr[L-2:0], 1'b0};
          pt_sr              <= {pt_sr[Y-2:0], 1'b0};
          i                  <= i + 1'b1;
          if (i == CW'(MAX_LEN - 1)) begin
            start_cnt <= '0;
            state     <= START;
          end
        end
        START: begin
          encryption_startxSO <= 1'b1;
          start_cnt           <= start_cnt + 4'd1;
          if (start_cnt == 4'(START_CYCLES - 1)) state <= WAIT;
        end
        WAIT: begin
          if (encryption_readyxSI) state <= DONE;
        end
        DONE: begin
          donexSO <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aead_serial_loader.sv
// Directed-sequence bench with randomized operands, checked against a
// transaction-level model of the serial stream and handshake timing.
module tb_aead_serial_loader;
  localparam int K       = 128;
  localparam int Y       = 64;
  localparam int L       = 40;
  localparam int SC      = 5;
  localparam int MAX_LEN = 128;

  logic         clk = 1'b0;
  logic         rst, load_valid, load_ready;
  logic [K-1:0] key;
  logic [127:0] nonce;
  logic [L-1:0] ad;
  logic [Y-1:0] pt;
  logic         key_s, nonce_s, ad_s, pt_s, shift_en, start, enc_ready, done;
  logic [K-1:0] nk;
  logic [127:0] nn;
  logic [L-1:0] na;
  logic [Y-1:0] np;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  aead_serial_loader #(.K(K), .Y(Y), .L(L), .START_CYCLES(SC)) dut (
    .clk(clk), .rst(rst),
    .load_validxSI(load_valid), .load_readyxSO(load_ready),
    .keyxDI(key), .noncexDI(nonce), .associated_dataxDI(ad), .plain_textxDI(pt),
    .keyxSO(key_s), .noncexSO(nonce_s), .associated_dataxSO(ad_s), .plain_textxSO(pt_s),
    .shift_enxSO(shift_en), .encryption_startxSO(start),
    .encryption_readyxSI(enc_ready), .donexSO(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic wait_ready();
    int waited = 0;
    while (!load_ready && waited < 400) begin
      step();
      waited++;
    end
    chk("wait_load_ready", load_ready, 1'b1);
  endtask

  // One full transaction; done is expected MAX_LEN+SC+w+2 edges after acceptance
  task automatic run_txn(input logic [K-1:0] k_, input logic [127:0] n_,
                         input logic [L-1:0] a_, input logic [Y-1:0] p_,
                         input int w, input bit early, input bit busy,
                         input bit hold, input bit immediate);
    int waited = 0;
    int n = 0;
    int shifts = 0, starts = 0, first_shift = -1, last_shift = -1, first_start = -1;
    int done_cnt = 0, done_at = -1, stray = 0, ready_bad = 0;
    logic [MAX_LEN-1:0] krx = '0, nrx = '0, arx = '0, prx = '0;
    enc_ready = early;
    while (!load_ready && waited < 400) begin
      step();
      waited++;
    end
    if (immediate) chk("b2b_wait_cycles", waited, 0);
    key = k_; nonce = n_; ad = a_; pt = p_;
    load_valid = 1'b1;
    step();
    if (!hold) load_valid = 1'b0;
    while (done_at < 0 && n < MAX_LEN + SC + w + 40) begin
      step();
      n++;
      if (shift_en) begin
        shifts++;
        if (first_shift < 0) first_shift = n;
        last_shift = n;
        krx = {krx[MAX_LEN-2:0], key_s};
        nrx = {nrx[MAX_LEN-2:0], nonce_s};
        arx = {arx[MAX_LEN-2:0], ad_s};
        prx = {prx[MAX_LEN-2:0], pt_s};
      end else if (key_s | nonce_s | ad_s | pt_s) stray++;
      if (start) begin
        starts++;
        if (first_start < 0) first_start = n;
        if (shift_en) stray++;
      end
      if (done) begin
        done_cnt++;
        done_at = n;
        if (hold) begin
          key = nk; nonce = nn; ad = na; pt = np;
        end
      end
      if (load_ready) ready_bad++;
      if (busy) begin
        if (n == 50 || n == MAX_LEN + SC + 2) begin
          load_valid = 1'b1;
          key = rnd128(); nonce = rnd128(); ad = L'(rnd128()); pt = Y'(rnd128());
        end else load_valid = 1'b0;
      end
      if (!early && n == MAX_LEN + SC + w) enc_ready = 1'b1;
    end
    chk("shift_count", shifts, MAX_LEN);
    chk("shift_first", first_shift, 1);
    chk("shift_last", last_shift, MAX_LEN);
    chk("key_stream", krx, k_);
    chk("nonce_stream", nrx, n_);
    chk("pt_stream", prx, {p_, {(MAX_LEN-Y){1'b0}}});
    chk("ad_stream", arx, {a_, {(MAX_LEN-L){1'b0}}});
    chk("start_count", starts, SC);
    chk("start_first", first_start, MAX_LEN + 1);
    chk("stray_outputs", stray, 0);
    chk("done_count", done_cnt, 1);
    chk("latency", done_at + 1, 1 + MAX_LEN + SC + (w + 1) + 1);
    if (!early) chk("done_after_ready", done_at - (MAX_LEN + SC + w), 2);
    chk("ready_low_busy", ready_bad, 0);
    step();
    chk("done_single", done, 1'b0);
    chk("ready_returns", load_ready, 1'b1);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; load_valid = 1'b0; enc_ready = 1'b0;
    key = '0; nonce = '0; ad = '0; pt = '0;
    nk = '0; nn = '0; na = '0; np = '0;
    repeat (2) step();
    chk("reset_outputs", {shift_en, start, done, key_s, nonce_s, ad_s, pt_s}, 7'b0);
    chk("reset_ready", load_ready, 1'b1);
    rst = 1'b0;
    step();
    chk("ready_after_release", load_ready, 1'b1);

    run_txn(128'h000102030405060708090A0B0C0D0E0F, 128'h101112131415161718191A1B1C1D1E1F,
            40'hA5A5A5A5A5, 64'h0123456789ABCDEF, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn(rnd128(), rnd128(), L'(rnd128()), Y'(rnd128()), 20, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn(rnd128(), rnd128(), L'(rnd128()), Y'(rnd128()), 0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_txn(rnd128(), rnd128(), L'(rnd128()), Y'(rnd128()), 20, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of the shift phase, with load_valid asserted alongside
    wait_ready();
    key = rnd128(); nonce = rnd128(); ad = L'(rnd128()); pt = Y'(rnd128());
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    repeat (51) step();
    chk("mid_shift_active", shift_en, 1'b1);
    rst = 1'b1; load_valid = 1'b1;
    step();
    chk("shift_abort_outputs", {shift_en, start, done, key_s, nonce_s, ad_s, pt_s}, 7'b0);
    chk("shift_abort_ready", load_ready, 1'b1);
    rst = 1'b0; load_valid = 1'b0;
    cnt = 0;
    repeat (6) begin
      step();
      if (shift_en | start | done | !load_ready) cnt++;
    end
    chk("shift_abort_quiet", cnt, 0);
    run_txn(rnd128(), rnd128(), L'(rnd128()), Y'(rnd128()), 2, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during the start pulse
    wait_ready();
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    repeat (MAX_LEN + 2) step();
    chk("mid_start_active", start, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt = 0;
    repeat (10) begin
      if (shift_en | start | done) cnt++;
      step();
    end
    chk("start_abort_quiet", cnt, 0);
    chk("start_abort_ready", load_ready, 1'b1);

    // Back-to-back with load_valid held high across both transactions
    nk = rnd128(); nn = rnd128(); na = L'(rnd128()); np = Y'(rnd128());
    run_txn(rnd128(), rnd128(), L'(rnd128()), Y'(rnd128()), 1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_txn(nk, nn, na, np, 4, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int t = 0; t < 3; t++)
      run_txn(rnd128(), rnd128(), L'(rnd128()), Y'(rnd128()), int'($urandom_range(1, 8)),
              1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
